rom_arbiter: RTL and testbench
==============================

ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 4, meaning: grants to other clients a pending client 1/2 tolerates before it is promoted (range 1-15).
REQ-002 SHALL have parameter HIT_EN, default 1, meaning: 1 enables the last-address hit buffer; 0 sends every request to memory.
REQ-003 SHALL have port clk  in  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port init_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports cN_req  in  1, cN_ack  out  1, cN_a  in  [23:1], cN_q  out  [15:0] for N=0 (68k), 1 (Z80), 2 (DMA): toggle-handshake ROM read clients.
REQ-006 SHALL have port inval  in  1  single-cycle pulse; ROM contents changed (ROM write or bank switch).
REQ-007 SHALL have ports mem_req  out  1, mem_ack  in  1, mem_a  out  [23:1], mem_q  in  [15:0]: toggle handshake toward the SDRAM ROM read port.
REQ-008 SHALL have port busy  out  1  high while a memory access is outstanding.

Function
REQ-009 Client N pending SHALL mean cN_req != cN_ack; completion SHALL set cN_ack <= cN_req in the same cycle cN_q is updated.
REQ-010 Memory access SHALL issue by toggling mem_req with mem_a valid in that cycle; it SHALL be complete in the first cycle mem_ack == mem_req, with mem_q captured that cycle.
REQ-011 FSM SHALL have states IDLE and BUSY; IDLE to BUSY on a miss grant; BUSY to IDLE on memory completion.
REQ-012 In IDLE with any client pending, exactly one winner SHALL be chosen per cycle: promoted client 1, else promoted client 2, else lowest-numbered pending client.
REQ-013 Clients 1 and 2 SHALL each keep a 4-bit wait counter: +1 whenever another client is granted while it is pending, cleared when it is granted, saturating at MAX_WAIT; counter == MAX_WAIT SHALL promote it.
REQ-014 Hit buffer: one entry {valid, addr[23:1], data[15:0]}; hit SHALL mean HIT_EN && valid && winner address == entry addr.
REQ-015 On hit, winner SHALL complete in the grant cycle (ack and q visible one clock after the req toggle is sampled), no mem_req toggle, FSM stays IDLE.
REQ-016 On miss, mem_a SHALL latch winner address, mem_req SHALL toggle, FSM SHALL enter BUSY with winner index latched.
REQ-017 On BUSY completion, the latched client SHALL complete with mem_q and, if not poisoned, the entry SHALL load {1, mem_a, mem_q}.
REQ-018 No new grant SHALL occur in BUSY; requests arriving in BUSY stay pending and are arbitrated in the next IDLE cycle.
REQ-019 inval SHALL clear valid the next cycle; inval during BUSY SHALL poison the in-flight access (data still returned to the client, not cached); poison SHALL clear on entering IDLE.
REQ-020 inval coincident with a hit grant SHALL take precedence: the request is treated as a miss.
REQ-021 A client toggling cN_req while already pending is a protocol violation; behaviour undefined, not checked.
REQ-022 busy SHALL equal (state == BUSY).

Reset
REQ-023 init_n low SHALL asynchronously force: state IDLE, all cN_ack 0, all cN_q 0, mem_req 0, mem_a 0, busy 0, valid 0, poison 0, wait counters 0.
REQ-024 Reset mid-access SHALL abandon the access; the downstream port is reset by the same init_n so that mem_ack == 0 afterwards.

Verification
REQ-025 c0 toggles, a=0x000100, memory returns 0x1234 after 10 cycles -> mem_req toggles once, c0_q=0x1234, c0_ack toggles on completion cycle.
REQ-026 Repeat c1 read of 0x000100 with no inval -> c1_ack toggles 1 cycle after sampled toggle, c1_q=0x1234, mem_req unchanged.
REQ-027 c0, c1, c2 all pending at once -> order c0, c1, c2; each sees exactly one ack toggle.
REQ-028 c0 re-requests every cycle it completes, c2 pending, MAX_WAIT=4 -> c2 granted after 4 c0 grants.
REQ-029 inval pulsed during a BUSY miss for 0x000200 -> client gets data; next read of 0x000200 issues a new mem_req.
REQ-030 init_n asserted during BUSY -> all outputs 0 immediately; after release a fresh c0 request completes normally.

Source files
------------

// File: rtl/rom_arbiter.sv
// Three-client ROM read arbiter with a one-entry last-address hit buffer.
// Toggle handshakes on the client side and on the SDRAM side.
module rom_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter bit HIT_EN   = 1'b1
) (
  input  logic        clk,
  input  logic        init_n,
  input  logic        c0_req,
  output logic        c0_ack,
  input  logic [23:1] c0_a,
  output logic [15:0] c0_q,
  input  logic        c1_req,
  output logic        c1_ack,
  input  logic [23:1] c1_a,
  output logic [15:0] c1_q,
  input  logic        c2_req,
  output logic        c2_ack,
  input  logic [23:1] c2_a,
  output logic [15:0] c2_q,
  input  logic        inval,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [23:1] mem_a,
  input  logic [15:0] mem_q,
  output logic        busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] MW = 4'(MAX_WAIT);

  state_t      state, state_nx;
  logic [2:0]  req, ack, pend;
  logic [15:0] q_r [3];
  logic [1:0]  win, widx;
  logic [23:1] win_a;
  logic        prom1, prom2;
  logic        grant, hit, mem_done;
  logic        valid, poison;
  logic [23:1] ent_a;
  logic [15:0] ent_d;
  logic [3:0]  w1, w2;

  assign req    = {c2_req, c1_req, c0_req};
  assign pend   = req ^ ack;
  assign c0_ack = ack[0];
  assign c1_ack = ack[1];
  assign c2_ack = ack[2];
  assign c0_q   = q_r[0];
  assign c1_q   = q_r[1];
  assign c2_q   = q_r[2];
  assign busy   = (state == BUSY);

  assign prom1 = pend[1] && (w1 == MW);
  assign prom2 = pend[2] && (w2 == MW);

  always_comb begin
    win = 2'd2;
    priority case (1'b1)
      prom1:   win = 2'd1;
      prom2:   win = 2'd2;
      pend[0]: win = 2'd0;
      pend[1]: win = 2'd1;
      default: win = 2'd2;
    endcase
  end

  always_comb begin
    win_a = c0_a;
    unique case (win)
      2'd1:    win_a = c1_a;
      2'd2:    win_a = c2_a;
      default: win_a = c0_a;
    endcase
  end

  // a coincident inval forces the request down the miss path
  assign grant    = (state == IDLE) && (|pend);
  assign hit      = HIT_EN && valid && (win_a == ent_a) && !inval;
  assign mem_done = (state == BUSY) && (mem_ack == mem_req);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant && !hit) state_nx = BUSY;
      BUSY:    if (mem_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      ack     <= 3'b000;
      for (int i = 0; i < 3; i++) q_r[i] <= 16'h0000;
      mem_req <= 1'b0;
      mem_a   <= '0;
      widx    <= 2'd0;
      valid   <= 1'b0;
      poison  <= 1'b0;
      ent_a   <= '0;
      ent_d   <= 16'h0000;
      w1      <= 4'd0;
      w2      <= 4'd0;
    end else begin
      if (grant) begin
        if (hit) begin
          ack[win] <= req[win];
          q_r[win] <= ent_d;
        end else begin
          mem_a   <= win_a;
          mem_req <= ~mem_req;
          widx    <= win;
        end
        if (win == 2'd1)              w1 <= 4'd0;
        else if (pend[1] && w1 != MW) w1 <= w1 + 4'd1;
        if (win == 2'd2)              w2 <= 4'd0;
        else if (pend[2] && w2 != MW) w2 <= w2 + 4'd1;
      end
      if (mem_done) begin
        ack[widx] <= req[widx];
        q_r[widx] <= mem_q;
        if (!poison) begin
          ent_a <= mem_a;
          ent_d <= mem_q;
        end
      end
      if (inval)                    valid <= 1'b0;
      else if (mem_done && !poison) valid <= 1'b1;
      if (mem_done)                 poison <= 1'b0;
      else if (busy && inval)       poison <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: vector table plus hand sequences
// for fairness, in-flight invalidation and mid-access reset.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        init_n = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [23:1] a [3];
  logic        inval = 1'b0;
  logic [2:0]  ack;
  logic [15:0] q0, q1, q2;
  logic        mem_req, mem_ack, busy;
  logic [23:1] mem_a;
  logic [15:0] mem_q;
  logic [3:0]  mcnt;

  int nchk = 0;
  int nerr = 0;
  int mem_toggles = 0;
  int ack_cnt [3];
  int order [$];

  always #5 clk = ~clk;

  rom_arbiter #(.MAX_WAIT(4), .HIT_EN(1'b1)) dut (
    .clk(clk), .init_n(init_n),
    .c0_req(req[0]), .c0_ack(ack[0]), .c0_a(a[0]), .c0_q(q0),
    .c1_req(req[1]), .c1_ack(ack[1]), .c1_a(a[1]), .c1_q(q1),
    .c2_req(req[2]), .c2_ack(ack[2]), .c2_a(a[2]), .c2_q(q2),
    .inval(inval),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a), .mem_q(mem_q),
    .busy(busy)
  );

  function automatic logic [15:0] mem_fn(input logic [23:1] ad);
    logic [15:0] lo;
    lo = ad[16:1];
    return (ad == 23'h000100) ? 16'h1234 : ~lo;
  endfunction

  // memory answers 10 cycles after seeing a new request
  always @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      mem_ack <= 1'b0;
      mem_q   <= 16'h0000;
      mcnt    <= 4'd0;
    end else if (mem_req != mem_ack) begin
      if (mcnt == 4'd9) begin
        mem_ack <= mem_req;
        mem_q   <= mem_fn(mem_a);
        mcnt    <= 4'd0;
      end else begin
        mcnt <= mcnt + 4'd1;
      end
    end
  end

  always @(mem_req) mem_toggles++;
  always @(ack[0]) begin ack_cnt[0]++; order.push_back(0); end
  always @(ack[1]) begin ack_cnt[1]++; order.push_back(1); end
  always @(ack[2]) begin ack_cnt[2]++; order.push_back(2); end

  function automatic logic [15:0] qof(input int c);
    return (c == 0) ? q0 : (c == 1) ? q1 : q2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " acks"}, {29'd0, ack}, 32'd0);
    chk({nm, " q"}, {q0 | q1 | q2}, 32'd0);
    chk({nm, " mem_req"}, {31'd0, mem_req}, 32'd0);
    chk({nm, " mem_a"}, {9'd0, mem_a}, 32'd0);
    chk({nm, " busy"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_ack(input int c, input string nm, output int lat);
    bit done = 0;
    lat = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      inval = 1'b0;
      lat++;
      if (ack[c] == req[c]) done = 1;
    end
    if (!done) chk({nm, " timeout"}, 0, 1);
  endtask

  task automatic wait_busy(input string nm);
    bit done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (busy) done = 1;
    end
    if (!done) chk({nm, " busy timeout"}, 0, 1);
  endtask

  // im: 0 none, 1 inval pulse before request, 2 inval with the request
  task automatic do_read(input int c, input logic [23:1] ad, input int im,
                         input logic [15:0] eq, input bit miss,
                         input string nm);
    int mt0, ac0, lat;
    @(negedge clk);
    if (im == 1) begin
      inval = 1'b1;
      @(negedge clk);
      inval = 1'b0;
    end
    mt0 = mem_toggles;
    ac0 = ack_cnt[c];
    a[c] = ad;
    req[c] = ~req[c];
    if (im == 2) inval = 1'b1;
    wait_ack(c, nm, lat);
    chk({nm, " q"}, {16'd0, qof(c)}, {16'd0, eq});
    chk({nm, " ack toggles"}, ack_cnt[c] - ac0, 1);
    chk({nm, " mem toggles"}, mem_toggles - mt0, {31'd0, miss});
    if (!miss) chk({nm, " hit latency"}, lat, 1);
  endtask

  typedef struct {
    int          c;
    logic [23:1] ad;
    int          im;
    logic [15:0] q;
    bit          miss;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int g0, mt0, lat;
    bit stop;
    tbl[0] = '{0, 23'h000100, 0, 16'h1234, 1'b1};
    tbl[1] = '{1, 23'h000100, 0, 16'h1234, 1'b0};
    tbl[2] = '{2, 23'h000100, 0, 16'h1234, 1'b0};
    tbl[3] = '{0, 23'h000200, 0, 16'hFDFF, 1'b1};
    tbl[4] = '{1, 23'h000200, 0, 16'hFDFF, 1'b0};
    tbl[5] = '{0, 23'h000200, 1, 16'hFDFF, 1'b1};
    tbl[6] = '{2, 23'h000200, 2, 16'hFDFF, 1'b1};
    tbl[7] = '{1, 23'h000200, 0, 16'hFDFF, 1'b0};
    tbl[8] = '{2, 23'h000300, 0, 16'hFCFF, 1'b1};
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      ack_cnt[i] = 0;
    end

    #12;
    chk_zero("reset");
    @(negedge clk);
    init_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++)
      do_read(tbl[i].c, tbl[i].ad, tbl[i].im, tbl[i].q, tbl[i].miss,
              $sformatf("vec%0d", i));

    // all three clients pending together
    @(negedge clk);
    order.delete();
    for (int i = 0; i < 3; i++) ack_cnt[i] = 0;
    a[0] = 23'h000400;
    a[1] = 23'h000500;
    a[2] = 23'h000600;
    req = ~req;
    wait_ack(0, "all3 c0", lat);
    wait_ack(1, "all3 c1", lat);
    wait_ack(2, "all3 c2", lat);
    repeat (2) @(negedge clk);
    chk("all3 count", order.size(), 3);
    if (order.size() == 3) begin
      chk("all3 first", order[0], 0);
      chk("all3 second", order[1], 1);
      chk("all3 third", order[2], 2);
    end
    chk("all3 c0 q", {16'd0, q0}, 32'h0000FBFF);
    chk("all3 c1 q", {16'd0, q1}, 32'h0000FAFF);
    chk("all3 c2 q", {16'd0, q2}, 32'h0000F9FF);

    // c0 hammers hits while c2 waits for promotion
    @(negedge clk);
    mt0 = mem_toggles;
    g0 = 0;
    stop = 0;
    a[0] = 23'h000600;
    a[2] = 23'h000700;
    req[0] = ~req[0];
    req[2] = ~req[2];
    for (int k = 0; k < 50 && !stop; k++) begin
      @(negedge clk);
      if (mem_toggles != mt0) stop = 1;
      else if (ack[0] == req[0]) begin
        g0++;
        req[0] = ~req[0];
      end
    end
    chk("fair c2 granted", {31'd0, stop}, 1);
    chk("fair c0 grants", g0, 4);
    wait_ack(2, "fair c2", lat);
    wait_ack(0, "fair c0", lat);
    chk("fair c2 q", {16'd0, q2}, 32'h0000F8FF);
    chk("fair c0 q", {16'd0, q0}, 32'h0000F9FF);

    // inval while the miss for 0x200 is in flight
    @(negedge clk);
    a[1] = 23'h000200;
    req[1] = ~req[1];
    wait_busy("poison");
    inval = 1'b1;
    wait_ack(1, "poison", lat);
    chk("poison c1 q", {16'd0, q1}, 32'h0000FDFF);
    do_read(0, 23'h000200, 0, 16'hFDFF, 1'b1, "poison reread");

    // reset in the middle of an access
    @(negedge clk);
    a[0] = 23'h000800;
    req[0] = ~req[0];
    wait_busy("midreset");
    #2;
    init_n = 1'b0;
    req = 3'b000;
    #1;
    chk_zero("midreset");
    @(negedge clk);
    init_n = 1'b1;
    do_read(0, 23'h000100, 0, 16'h1234, 1'b1, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
